// File: rtl/conv_ctrl_pkg.sv
// Shared state encoding, status bit map and config field offsets for the conv job controller.
package conv_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_RUN       = 3'd3,
        S_FINISH    = 3'd4
    } state_t;

    localparam int ST_BUSY       = 0;
    localparam int ST_DONE       = 1;
    localparam int ST_ERR_CFG    = 2;
    localparam int ST_OVERRUN    = 3;
    localparam int ST_TIMEOUT    = 4;
    localparam int ST_JOBCNT_LSB = 5;
    localparam int JOBCNT_W      = 3;

    localparam int CFG_SIZEX_LSB = 0;
    localparam int CFG_SIZEY_LSB = 8;

    // A job is legal only for a non-empty region no taller than it is wide.
    function automatic logic cfg_size_ok(input int unsigned size_x,
                                         input int unsigned size_y,
                                         input int unsigned max_size);
        return (size_y >= 1) && (size_y <= size_x) && (size_x <= max_size);
    endfunction

endpackage

// File: rtl/conv_ctrl_wdt.sv
// Stall watchdog: cleared before a job, counts while enabled, trips as the count reaches TIMEOUT_CYC.
module conv_ctrl_wdt #(
    parameter int TIMEOUT_W   = 16,
    parameter int TIMEOUT_CYC = 4095
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic trip
);

    localparam logic [TIMEOUT_W-1:0] TRIP_AT = TIMEOUT_W'(TIMEOUT_CYC - 1);

    logic [TIMEOUT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    // Fires on the increment that brings the count to TIMEOUT_CYC.
    assign trip = inc && (count == TRIP_AT);

endmodule

// File: rtl/conv_job_ctrl.sv
// Job sequencer for the convolution core: validates cfg, pulses core start, tracks busy/done, sticky irq.
// start -> core_start next cycle; done -> irq two edges later. Watchdog built only with CONV_JOB_CTRL_WDT_EN.
module conv_job_ctrl
    import conv_ctrl_pkg::*;
#(
    parameter int SIZE_W      = 6,
    parameter int MAX_SIZE    = 32,
    parameter int TIMEOUT_W   = 16,
    parameter int TIMEOUT_CYC = 4095
) (
    input  logic              clk,
    input  logic              rst_a,
    input  logic              en_s,
    input  logic              start_i,
    input  logic [31:0]       cfg_i,
    input  logic              int_clr_i,
    input  logic              core_busy_i,
    input  logic              core_done_i,
    output logic              core_start_o,
    output logic [SIZE_W-1:0] core_sizeX_o,
    output logic [SIZE_W-1:0] core_sizeY_o,
    output logic              busy_o,
    output logic              int_done_o,
    output logic [7:0]        status_o
);

    state_t              state;
    logic                core_start_q;
    logic [SIZE_W-1:0]   size_x_q;
    logic [SIZE_W-1:0]   size_y_q;

    logic                done_flag;
    logic                err_cfg_flag;
    logic                overrun_flag;
    logic                timeout_flag;
    logic [JOBCNT_W-1:0] job_cnt;

    logic [SIZE_W-1:0]   cfg_size_x;
    logic [SIZE_W-1:0]   cfg_size_y;
    logic                cfg_ok;
    logic                job_timeout;
    logic                unused_cfg_bits;

    assign cfg_size_x = cfg_i[CFG_SIZEX_LSB +: SIZE_W];
    assign cfg_size_y = cfg_i[CFG_SIZEY_LSB +: SIZE_W];
    assign cfg_ok     = cfg_size_ok(32'(cfg_size_x), 32'(cfg_size_y), MAX_SIZE);

    assign unused_cfg_bits = ^{cfg_i[31:CFG_SIZEY_LSB+SIZE_W], cfg_i[CFG_SIZEY_LSB-1:SIZE_W]};

`ifdef CONV_JOB_CTRL_WDT_EN
    logic wdt_trip;

    conv_ctrl_wdt #(
        .TIMEOUT_W   (TIMEOUT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdt (
        .clk  (clk),
        .rst  (rst_a),
        .clr  (en_s && (state == S_LAUNCH)),
        .inc  (en_s && ((state == S_WAIT_BUSY) || (state == S_RUN))),
        .trip (wdt_trip)
    );

    // A done arriving on the trip cycle still completes the job normally.
    assign job_timeout = wdt_trip && !core_done_i;
`else
    logic [31:0] unused_wdt_cfg;

    assign unused_wdt_cfg = TIMEOUT_W ^ TIMEOUT_CYC;
    assign job_timeout    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state        <= S_IDLE;
            core_start_q <= 1'b0;
            size_x_q     <= '0;
            size_y_q     <= '0;
        end else if (en_s) begin
            core_start_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i && cfg_ok) begin
                        size_x_q     <= cfg_size_x;
                        size_y_q     <= cfg_size_y;
                        core_start_q <= 1'b1;
                        state        <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (core_done_i) begin
                        state <= S_FINISH;
                    end else if (core_busy_i) begin
                        state <= S_RUN;
                    end else if (job_timeout) begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (core_done_i) begin
                        state <= S_FINISH;
                    end else if (job_timeout) begin
                        state <= S_IDLE;
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Clear first, then any set in the same cycle overrides it.
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            done_flag    <= 1'b0;
            err_cfg_flag <= 1'b0;
            overrun_flag <= 1'b0;
            timeout_flag <= 1'b0;
            job_cnt      <= '0;
        end else if (en_s) begin
            if (int_clr_i) begin
                done_flag    <= 1'b0;
                err_cfg_flag <= 1'b0;
                overrun_flag <= 1'b0;
                timeout_flag <= 1'b0;
            end
            if (state == S_FINISH) begin
                done_flag <= 1'b1;
                job_cnt   <= job_cnt + JOBCNT_W'(1);
            end
            if ((state == S_IDLE) && start_i && !cfg_ok) begin
                err_cfg_flag <= 1'b1;
            end
            if ((state != S_IDLE) && start_i) begin
                overrun_flag <= 1'b1;
            end
            if (job_timeout) begin
                timeout_flag <= 1'b1;
            end
        end
    end

    // Frozen while disabled, so a held LAUNCH must not leak a pulse to the core.
    assign core_start_o = core_start_q && en_s;
    assign core_sizeX_o = size_x_q;
    assign core_sizeY_o = size_y_q;
    assign busy_o       = (state != S_IDLE);
    assign int_done_o   = done_flag || err_cfg_flag || timeout_flag;

    always_comb begin
        status_o                                = '0;
        status_o[ST_BUSY]                       = busy_o;
        status_o[ST_DONE]                       = done_flag;
        status_o[ST_ERR_CFG]                    = err_cfg_flag;
        status_o[ST_OVERRUN]                    = overrun_flag;
        status_o[ST_TIMEOUT]                    = timeout_flag;
        status_o[ST_JOBCNT_LSB +: JOBCNT_W]     = job_cnt;
    end

endmodule

// File: tb/tb_conv_job_ctrl.sv
// Directed + randomized bench for conv_job_ctrl against a transaction-level model of flags and job count.
module tb_conv_job_ctrl;

    localparam int SW   = 6;
    localparam int MAXS = 32;
    localparam int TO   = 50;

    logic          clk = 1'b0;
    logic          rst_a = 1'b1;
    logic          en_s = 1'b0;
    logic          start_i = 1'b0;
    logic [31:0]   cfg_i = 32'h0;
    logic          int_clr_i = 1'b0;
    logic          core_busy_i = 1'b0;
    logic          core_done_i = 1'b0;
    logic          core_start_o;
    logic [SW-1:0] core_sizeX_o;
    logic [SW-1:0] core_sizeY_o;
    logic          busy_o;
    logic          int_done_o;
    logic [7:0]    status_o;

    int n_vec = 0;
    int n_err = 0;
    int n_pulses = 0;

    bit m_done, m_err, m_ovr, m_tmo;
    int m_jobs = 0;
    int m_launches = 0;
    int last_sx = 0;
    int last_sy = 0;

    conv_job_ctrl #(
        .SIZE_W      (SW),
        .MAX_SIZE    (MAXS),
        .TIMEOUT_W   (16),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk          (clk),
        .rst_a        (rst_a),
        .en_s         (en_s),
        .start_i      (start_i),
        .cfg_i        (cfg_i),
        .int_clr_i    (int_clr_i),
        .core_busy_i  (core_busy_i),
        .core_done_i  (core_done_i),
        .core_start_o (core_start_o),
        .core_sizeX_o (core_sizeX_o),
        .core_sizeY_o (core_sizeY_o),
        .busy_o       (busy_o),
        .int_done_o   (int_done_o),
        .status_o     (status_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (core_start_o === 1'b1) n_pulses++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit legal(input int sx, input int sy);
        return (sy >= 1) && (sy <= sx) && (sx <= MAXS);
    endfunction

    function automatic logic [7:0] exp_status(input bit busy);
        logic [2:0] jc;
        jc = 3'(m_jobs % 8);
        return {jc, m_tmo, m_ovr, m_err, m_done, busy};
    endfunction

    task automatic model_reset();
        {m_done, m_err, m_ovr, m_tmo} = 4'b0;
        m_jobs  = 0;
        last_sx = 0;
        last_sy = 0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_status"}, status_o, exp_status(1'b0));
        chk({tag, "_irq"}, int_done_o, m_done | m_err | m_tmo);
    endtask

    task automatic set_cfg(input int sx, input int sy);
        logic [31:0] c;
        c = $urandom;
        c[5:0]  = 6'(sx);
        c[13:8] = 6'(sy);
        cfg_i = c;
    endtask

    task automatic clear_irq();
        int_clr_i = 1'b1;
        tick();
        int_clr_i = 1'b0;
        {m_done, m_err, m_ovr, m_tmo} = 4'b0;
        check_idle("clr");
    endtask

    task automatic run_job(input int sx, input int sy, input int pre, input int blen,
                           input bit fast, input bit ovr, input bit clr_fin);
        set_cfg(sx, sy);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("launch_pulse", core_start_o, 1);
        chk("latch_x", core_sizeX_o, sx);
        chk("latch_y", core_sizeY_o, sy);
        chk("launch_busy", busy_o, 1);
        m_launches++;
        last_sx = sx;
        last_sy = sy;
        if (ovr) start_i = 1'b1;
        tick();
        start_i = 1'b0;
        if (ovr) m_ovr = 1'b1;
        chk("single_pulse", core_start_o, 0);
        cfg_i = $urandom;
        repeat (pre) tick();
        if (fast) begin
            core_done_i = 1'b1;
            tick();
            core_done_i = 1'b0;
        end else begin
            core_busy_i = 1'b1;
            repeat (blen) tick();
            core_busy_i = 1'b0;
            core_done_i = 1'b1;
            tick();
            core_done_i = 1'b0;
        end
        chk("finish_busy", busy_o, 1);
        chk("irq_latency", int_done_o, m_done | m_err | m_tmo);
        if (clr_fin) int_clr_i = 1'b1;
        tick();
        int_clr_i = 1'b0;
        if (clr_fin) {m_err, m_ovr, m_tmo} = 3'b0;
        m_done = 1'b1;
        m_jobs++;
        chk("hold_x", core_sizeX_o, sx);
        chk("hold_y", core_sizeY_o, sy);
        check_idle("job_end");
    endtask

    task automatic bad_cfg(input int sx, input int sy);
        set_cfg(sx, sy);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        m_err = 1'b1;
        chk("bad_no_start", core_start_o, 0);
        chk("bad_hold_x", core_sizeX_o, last_sx);
        chk("bad_hold_y", core_sizeY_o, last_sy);
        check_idle("bad");
    endtask

    initial begin
        model_reset();

        // Reset state
        #12;
        chk("rst_start", core_start_o, 0);
        chk("rst_sx", core_sizeX_o, 0);
        chk("rst_sy", core_sizeY_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_irq", int_done_o, 0);
        chk("rst_status", status_o, 0);
        @(negedge clk);
        rst_a = 1'b0;
        en_s  = 1'b1;

        // Nominal job
        repeat (4) tick();
        run_job(8, 3, 0, 20, 1'b0, 1'b0, 1'b0);
        chk("nominal_status", status_o, 8'b001_00010);
        chk("nominal_pulses", n_pulses, 1);

        // Bad configs, then clear
        bad_cfg(8, 0);
        bad_cfg(8, 9);
        chk("bad_err_bit", status_o[2], 1);
        chk("bad_irq", int_done_o, 1);
        clear_irq();
        chk("clr_low_bits", status_o[2:0], 0);

        // Overrun during RUN
        run_job(16, 16, 1, 10, 1'b0, 1'b1, 1'b0);
        chk("overrun_bit", status_o[3], 1);
        chk("overrun_jobcnt", status_o[7:5], 2);

        // Clear colliding with the done set
        run_job(5, 2, 2, 6, 1'b0, 1'b1, 1'b1);
        chk("collide_done", status_o[1], 1);
        chk("collide_ovr_clr", status_o[3], 0);

        // Enable freeze: start ignored, LAUNCH held without a pulse, done ignored
        set_cfg(12, 7);
        en_s = 1'b0;
        start_i = 1'b1;
        repeat (3) tick();
        start_i = 1'b0;
        chk("frz_idle_busy", busy_o, 0);
        chk("frz_idle_start", core_start_o, 0);
        en_s = 1'b1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        en_s = 1'b0;
        #1;
        chk("frz_launch_forced", core_start_o, 0);
        repeat (2) tick();
        chk("frz_launch_held", core_start_o, 0);
        chk("frz_launch_busy", busy_o, 1);
        en_s = 1'b1;
        #1;
        chk("frz_launch_resume", core_start_o, 1);
        m_launches++;
        last_sx = 12;
        last_sy = 7;
        tick();
        chk("frz_pulse_end", core_start_o, 0);
        core_busy_i = 1'b1;
        tick();
        en_s = 1'b0;
        core_done_i = 1'b1;
        start_i = 1'b1;
        tick();
        core_done_i = 1'b0;
        start_i = 1'b0;
        tick();
        chk("frz_run_busy", busy_o, 1);
        chk("frz_run_status", status_o, exp_status(1'b1));
        en_s = 1'b1;
        core_busy_i = 1'b0;
        core_done_i = 1'b1;
        tick();
        core_done_i = 1'b0;
        tick();
        m_done = 1'b1;
        m_jobs++;
        check_idle("frz_end");

        // Size boundaries
        run_job(32, 32, 0, 1, 1'b0, 1'b0, 1'b0);
        bad_cfg(33, 1);
        bad_cfg(0, 0);
        run_job(1, 1, 0, 0, 1'b1, 1'b0, 1'b0);
        bad_cfg(63, 63);

        // Randomized jobs
        for (int i = 0; i < 25; i++) begin
            int sx, sy;
            if ($urandom_range(0, 2) == 0) clear_irq();
            if ($urandom_range(0, 3) == 0) begin
                sx = $urandom_range(0, 63);
                sy = $urandom_range(0, 63);
            end else begin
                sx = $urandom_range(1, MAXS);
                sy = $urandom_range(1, sx);
            end
            if (legal(sx, sy))
                run_job(sx, sy, $urandom_range(0, 4), $urandom_range(1, 30),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)));
            else
                bad_cfg(sx, sy);
        end

        // Stalled core
        clear_irq();
        set_cfg(10, 4);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        m_launches++;
        last_sx = 10;
        last_sy = 4;
        tick();
`ifdef CONV_JOB_CTRL_WDT_EN
        begin
            int k;
            k = 0;
            while (busy_o === 1'b1 && k < 200) begin
                tick();
                k++;
            end
            chk("wdt_cycles", k, TO);
            m_tmo = 1'b1;
            check_idle("wdt");
        end
`else
        repeat (200) tick();
        chk("nowdt_busy", busy_o, 1);
        chk("nowdt_tmo", status_o[4], 0);
        core_done_i = 1'b1;
        tick();
        core_done_i = 1'b0;
        tick();
        m_done = 1'b1;
        m_jobs++;
        check_idle("nowdt_end");
`endif

        // Asynchronous reset mid-RUN
        run_job(6, 6, 0, 3, 1'b0, 1'b0, 1'b0);
        set_cfg(20, 5);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        m_launches++;
        tick();
        core_busy_i = 1'b1;
        tick();
        tick();
        #2;
        rst_a = 1'b1;
        #1;
        chk("arst_busy", busy_o, 0);
        chk("arst_status", status_o, 0);
        chk("arst_start", core_start_o, 0);
        chk("arst_irq", int_done_o, 0);
        chk("arst_sx", core_sizeX_o, 0);
        core_busy_i = 1'b0;
        model_reset();
        @(negedge clk);
        rst_a = 1'b0;
        tick();
        check_idle("post_rst");

        chk("pulse_total", n_pulses, m_launches);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
